// File: rtl/hk_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hk_spi_responder                                              |
// | Purpose  : Housekeeping SPI responder (mode 0, MSB first). Oversamples    |
// |            the SPI pads in the core clock domain, decodes command /      |
// |            address / data frames and drives a byte-wide register bus.    |
// | Ports    : clk, resetn        - core clock, async active-low reset        |
// |            SCK, CSB, SDI      - SPI pad inputs (CSB active low)           |
// |            SDO, sdo_enb       - SPI data out and its active-low enable    |
// |            reg_addr/wdata     - register bus address and write data       |
// |            reg_we/reg_re      - one-cycle write / read strobes            |
// |            reg_rdata          - read data, valid one clk after reg_re     |
// |            busy               - frame in progress                         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  SCK,
  input  logic                  CSB,
  input  logic                  SDI,
  output logic                  SDO,
  output logic                  sdo_enb,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_IGNORE = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Pad synchronisers. CSB chain resets low so that a CSB already held low
  // when reset releases never looks like a falling edge; a fresh frame needs
  // CSB to rise and fall again.
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] csb_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sck_prev_q;
  logic                   csb_prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_sync_q <= '0;
      csb_sync_q <= '0;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], CSB};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], SDI};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      csb_prev_q <= csb_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, csb_s, sdi_s;
  logic sck_rise, sck_fall, csb_fall;
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;

  state_e                state_q;
  logic [2:0]            bitcnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            tx_q;
  logic                  rd_q, wr_q;
  logic                  step_pend_q;   // second half of an end-of-data-byte action
  logic                  load_pend_q;   // reg_rdata is valid this clk
  logic                  sdo_q, sdo_enb_q, we_q, re_q, busy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;

  logic       byte_done;
  logic [7:0] rx_byte;
  assign byte_done = sck_rise && (bitcnt_q == 3'd7);
  assign rx_byte   = {shift_q[6:0], sdi_s};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      step_pend_q <= 1'b0;
      load_pend_q <= 1'b0;
      sdo_q       <= 1'b0;
      sdo_enb_q   <= 1'b1;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
    end else begin
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      load_pend_q <= re_q;
      if (load_pend_q) begin
        tx_q <= reg_rdata;
      end

      if (csb_s) begin
        // Frame ended or aborted: any partial byte is simply dropped.
        state_q     <= S_IDLE;
        bitcnt_q    <= 3'd0;
        sdo_q       <= 1'b0;
        sdo_enb_q   <= 1'b1;
        busy_q      <= 1'b0;
        step_pend_q <= 1'b0;
        load_pend_q <= 1'b0;
      end else begin
        // Byte-boundary actions split over two clks so that a write to A
        // always precedes the read of A+1.
        if (step_pend_q) begin
          step_pend_q <= 1'b0;
          if (wr_q) begin
            addr_q <= addr_q + ADDR_ONE;
          end
          if (rd_q) begin
            re_q <= 1'b1;
          end
        end

        if (sck_rise && (state_q != S_IDLE)) begin
          shift_q  <= rx_byte;
          bitcnt_q <= bitcnt_q + 3'd1;
        end

        case (state_q)
          S_IDLE: begin
            if (csb_fall) begin
              state_q  <= S_CMD;
              bitcnt_q <= 3'd0;
              busy_q   <= 1'b1;
            end
          end
          S_CMD: begin
            if (byte_done) begin
              if ((rx_byte == 8'h80) || (rx_byte == 8'h40) || (rx_byte == 8'hC0)) begin
                wr_q    <= rx_byte[7];
                rd_q    <= rx_byte[6];
                state_q <= S_ADDR;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_ADDR: begin
            if (byte_done) begin
              addr_q  <= ADDR_WIDTH'(rx_byte);
              re_q    <= rd_q;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (rd_q && sck_fall) begin
              sdo_q     <= tx_q[7];
              tx_q      <= {tx_q[6:0], 1'b0};
              sdo_enb_q <= 1'b0;
            end
            if (byte_done) begin
              step_pend_q <= 1'b1;
              if (wr_q) begin
                wdata_q <= rx_byte;
                we_q    <= 1'b1;
              end else begin
                addr_q <= addr_q + ADDR_ONE;
              end
            end
          end
          default: begin
            // S_IGNORE: hold until CSB rises.
          end
        endcase
      end
    end
  end

  assign SDO       = sdo_q;
  assign sdo_enb   = sdo_enb_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hk_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hk_spi_responder                                           |
// | Purpose  : Directed self-checking bench for hk_spi_responder. Acts as    |
// |            the SPI initiator and as the register-file model.             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hk_spi_responder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       SCK, CSB, SDI;
  logic       SDO, sdo_enb;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  int n_assert = 0;
  int n_fail   = 0;

  hk_spi_responder #(.SYNC_STAGES(2), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .SCK       (SCK),
    .CSB       (CSB),
    .SDI       (SDI),
    .SDO       (SDO),
    .sdo_enb   (sdo_enb),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register file model: unwritten locations read as addr+0x30, data is
  // returned one clk after reg_re.
  logic [7:0] wmem [256];
  bit [255:0] wvalid;
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= wvalid[reg_addr] ? wmem[reg_addr] : reg_addr + 8'h30;
    if (reg_we) begin
      wmem[reg_addr]   <= reg_wdata;
      wvalid[reg_addr] <= 1'b1;
    end
  end

  // Strobe log and bus-protocol monitors.
  int  cyc = 0;
  int  ev_kind[$];   // 1 = write, 2 = read
  int  ev_addr[$];
  int  ev_data[$];
  int  ev_cyc[$];
  bit  enb_low_seen;
  int  overlap_cnt = 0;
  int  stretch_cnt = 0;
  logic prev_we = 1'b0, prev_re = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_we) begin
      ev_kind.push_back(1); ev_addr.push_back(int'(reg_addr));
      ev_data.push_back(int'(reg_wdata)); ev_cyc.push_back(cyc);
    end
    if (reg_re) begin
      ev_kind.push_back(2); ev_addr.push_back(int'(reg_addr));
      ev_data.push_back(0); ev_cyc.push_back(cyc);
    end
    if (reg_we && reg_re) overlap_cnt++;
    if ((reg_we && prev_we) || (reg_re && prev_re)) stretch_cnt++;
    prev_we = reg_we;
    prev_re = reg_re;
    if (!sdo_enb) enb_low_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_log();
    ev_kind.delete(); ev_addr.delete(); ev_data.delete(); ev_cyc.delete();
    enb_low_seen = 1'b0;
  endtask

  // Half an SCK period = 5 core clocks.
  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_start();
    CSB = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    CSB = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Shifts nbits of tx (MSB first); SDO is sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      SDI = tx[i];
      half();
      rx[i] = SDO;
      SCK = 1'b1;
      half();
      SCK = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_sdo"},     {31'd0, SDO},     32'd0);
    chk({pfx, "_sdo_enb"}, {31'd0, sdo_enb}, 32'd1);
    chk({pfx, "_addr"},    {24'd0, reg_addr},  32'd0);
    chk({pfx, "_wdata"},   {24'd0, reg_wdata}, 32'd0);
    chk({pfx, "_we"},      {31'd0, reg_we},  32'd0);
    chk({pfx, "_re"},      {31'd0, reg_re},  32'd0);
    chk({pfx, "_busy"},    {31'd0, busy},    32'd0);
  endtask

  logic [7:0] rx, rx0, rx1;

  initial begin
    resetn = 1'b0; SCK = 1'b0; CSB = 1'b1; SDI = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    // Write single: 0x80, 0x05, 0xA5.
    clear_log();
    frame_start();
    chk("wr_busy", {31'd0, busy}, 32'd1);
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hA5, 8, rx);
    frame_end();
    chk("wr_nev",   ev_kind.size(), 1);
    chk("wr_kind",  ev_kind[0], 1);
    chk("wr_addr",  ev_addr[0], 32'h05);
    chk("wr_data",  ev_data[0], 32'hA5);
    chk("wr_enb",   {31'd0, enb_low_seen}, 32'd0);
    chk("wr_mem",   {24'd0, wmem[5]}, 32'hA5);
    chk("wr_busy_end", {31'd0, busy}, 32'd0);

    // Read stream: 0x40, 0x10, two dummy bytes.
    clear_log();
    frame_start();
    spi_bits(8'h40, 8, rx);
    spi_bits(8'h10, 8, rx);
    chk("rd_enb_addr", {31'd0, enb_low_seen}, 32'd0);
    spi_bits(8'h00, 8, rx0);
    spi_bits(8'h00, 8, rx1);
    chk("rd_enb_data", {31'd0, sdo_enb}, 32'd0);
    frame_end();
    chk("rd_byte0", {24'd0, rx0}, 32'h40);
    chk("rd_byte1", {24'd0, rx1}, 32'h41);
    chk("rd_nev",   ev_kind.size(), 3);
    chk("rd_ev0",   {ev_kind[0][15:0], ev_addr[0][15:0]}, {16'd2, 16'h10});
    chk("rd_ev1",   {ev_kind[1][15:0], ev_addr[1][15:0]}, {16'd2, 16'h11});
    chk("rd_enb_end", {31'd0, sdo_enb}, 32'd1);

    // Read-write with address wrap: 0xC0, 0xFF, 0x12, 0x34.
    clear_log();
    frame_start();
    spi_bits(8'hC0, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'h12, 8, rx0);
    spi_bits(8'h34, 8, rx1);
    frame_end();
    chk("rw_byte0", {24'd0, rx0}, 32'h2F);
    chk("rw_byte1", {24'd0, rx1}, 32'h30);
    chk("rw_nev",   ev_kind.size(), 5);
    chk("rw_ev0",   {ev_kind[0][7:0], ev_addr[0][7:0], 16'd0}, {8'd2, 8'hFF, 16'd0});
    chk("rw_ev1",   {ev_kind[1][7:0], ev_addr[1][7:0], ev_data[1][7:0], 8'd0}, {8'd1, 8'hFF, 8'h12, 8'd0});
    chk("rw_ev2",   {ev_kind[2][7:0], ev_addr[2][7:0], 16'd0}, {8'd2, 8'h00, 16'd0});
    chk("rw_ev3",   {ev_kind[3][7:0], ev_addr[3][7:0], ev_data[3][7:0], 8'd0}, {8'd1, 8'h00, 8'h34, 8'd0});
    chk("rw_we_re_gap", ev_cyc[2] - ev_cyc[1], 1);
    chk("rw_memFF", {24'd0, wmem[255]}, 32'h12);

    // Abort after 5 bits of the first write data byte.
    clear_log();
    frame_start();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hEE, 5, rx);
    frame_end();
    chk("abort_nev",  ev_kind.size(), 0);
    chk("abort_idle", {29'd0, dut.state_q}, 32'd0);
    frame_start();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h77, 8, rx);
    frame_end();
    chk("after_abort_nev", ev_kind.size(), 1);
    chk("after_abort_ev",  {ev_kind[0][7:0], ev_addr[0][7:0], ev_data[0][7:0], 8'd0}, {8'd1, 8'h01, 8'h77, 8'd0});

    // Bad command 0x3C, then a normal read of 0x20.
    clear_log();
    frame_start();
    spi_bits(8'h3C, 8, rx);
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hFF, 8, rx);
    frame_end();
    chk("bad_nev", ev_kind.size(), 0);
    chk("bad_enb", {31'd0, enb_low_seen}, 32'd0);
    frame_start();
    spi_bits(8'h40, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h00, 8, rx0);
    frame_end();
    chk("after_bad_data", {24'd0, rx0}, 32'h50);
    chk("after_bad_ev0",  {ev_kind[0][15:0], ev_addr[0][15:0]}, {16'd2, 16'h20});

    // Reset mid read with CSB held low.
    frame_start();
    spi_bits(8'h40, 8, rx);
    spi_bits(8'h30, 8, rx);
    spi_bits(8'h00, 3, rx);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("inrst");
    clear_log();
    resetn = 1'b1;
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h11, 8, rx);
    chk("rst_held_nev",  ev_kind.size(), 0);
    chk("rst_held_busy", {31'd0, busy}, 32'd0);
    chk("rst_held_enb",  {31'd0, enb_low_seen}, 32'd0);
    frame_end();
    frame_start();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h11, 8, rx);
    frame_end();
    chk("rst_new_nev", ev_kind.size(), 1);
    chk("rst_new_ev",  {ev_kind[0][7:0], ev_addr[0][7:0], ev_data[0][7:0], 8'd0}, {8'd1, 8'h07, 8'h11, 8'd0});

    chk("no_overlap", overlap_cnt, 0);
    chk("strobe_1clk", stretch_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
